// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RISC-V M-extension unit beside the execute-stage ALU.
// Multiplies finish after a fixed MUL_LATENCY. Divides use restoring division,
// one quotient bit per cycle, followed by a sign fixup cycle.
// Divide by zero and signed overflow are resolved in the accept cycle.
// The result is held until the execute/memory boundary takes it.
//
// Optional feature: define MULDIV_REMAINDER_CACHE_EN to keep the last completed
// divide (operands, signedness, quotient, remainder). A matching divide-class op
// then finishes in one cycle.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   flush               abort in-flight op, drop held result
//   issueValid/Ready    op handshake; issueOp selects MUL..REMU
//   operandA/B          rs1/rs2 values
//   issueTag            destination register tag
//   resultValid/Ready   result handshake
//   result, resultTag   operation result and its tag
//   busy                op in flight or result held
module execute_muldiv #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             issueValid,
  output logic             issueReady,
  input  logic [2:0]       issueOp,
  input  logic [XLEN-1:0]  operandA,
  input  logic [XLEN-1:0]  operandB,
  input  logic [TAG_W-1:0] issueTag,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] resultTag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIXUP, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [2:0]        op_q, op_d;
  logic              quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

`ifdef MULDIV_REMAINDER_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic              cache_signed_q, cache_signed_d;
  logic [XLEN-1:0]   cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
  logic [XLEN-1:0]   pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic              pend_signed_q, pend_signed_d;
  logic              cache_hit;
`endif

  // Decode of the op presented at issue
  logic accept, in_is_div, in_is_rem, in_signed, in_b_zero, in_ovf;
  assign accept    = issueValid && (state_q == ST_IDLE) && !flush;
  assign in_is_div = issueOp[2];
  assign in_is_rem = issueOp[1];
  assign in_signed = !issueOp[0];
  assign in_b_zero = (operandB == '0);
  assign in_ovf    = in_signed && (operandA == XMIN) && (operandB == '1);

`ifdef MULDIV_REMAINDER_CACHE_EN
  assign cache_hit = cache_valid_q && (operandA == cache_a_q) &&
                     (operandB == cache_b_q) && (in_signed == cache_signed_q);
`endif

  // Full-width product from sign-/zero-extended operands
  logic          ext_a_sgn, ext_b_sgn;
  logic [PW-1:0] a_ext, b_ext, prod_c;
  assign ext_a_sgn = (issueOp == 3'd1) || (issueOp == 3'd2);
  assign ext_b_sgn = (issueOp == 3'd1);
  assign a_ext  = {{XLEN{ext_a_sgn & operandA[XLEN-1]}}, operandA};
  assign b_ext  = {{XLEN{ext_b_sgn & operandB[XLEN-1]}}, operandB};
  assign prod_c = a_ext * b_ext;

  function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] op, input logic [PW-1:0] p);
    return (op == 3'd0) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // Operand magnitudes for the divider
  logic [XLEN-1:0] mag_a, mag_b;
  assign mag_a = (in_signed && operandA[XLEN-1]) ? -operandA : operandA;
  assign mag_b = (in_signed && operandB[XLEN-1]) ? -operandB : operandB;

  // One restoring step; in IDLE it starts from the fresh operands so the
  // accept cycle already produces the first quotient bit.
  logic            step_init, step_ge;
  logic [XLEN-1:0] s_rem, s_quo, s_dvsr, step_rem, step_quo;
  logic [XLEN:0]   shifted;
  assign step_init = (state_q == ST_IDLE);
  assign s_rem     = step_init ? '0    : rem_q;
  assign s_quo     = step_init ? mag_a : quo_q;
  assign s_dvsr    = step_init ? mag_b : dvsr_q;
  assign shifted   = {s_rem, s_quo[XLEN-1]};
  assign step_ge   = (shifted >= {1'b0, s_dvsr});
  assign step_rem  = step_ge ? XLEN'(shifted - {1'b0, s_dvsr}) : shifted[XLEN-1:0];
  assign step_quo  = {s_quo[XLEN-2:0], step_ge};

  // Sign fixup of the finished magnitudes
  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = quo_neg_q ? -quo_q : quo_q;
  assign r_fix = rem_neg_q ? -rem_q : rem_q;

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    tag_d     = tag_q;
`ifdef MULDIV_REMAINDER_CACHE_EN
    cache_valid_d  = cache_valid_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    pend_a_d       = pend_a_q;
    pend_b_d       = pend_b_q;
    pend_signed_d  = pend_signed_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d  = issueOp;
            tag_d = issueTag;
            if (!in_is_div) begin
              prod_d = prod_c;
              if (MUL_LATENCY == 1) begin
                result_d = mul_sel(issueOp, prod_c);
                state_d  = ST_DONE;
              end else begin
                cnt_d   = CNT_W'(MUL_LATENCY - 1);
                state_d = ST_MUL;
              end
            end else if (in_b_zero) begin
              result_d = in_is_rem ? operandA : '1;
              state_d  = ST_DONE;
            end else if (in_ovf) begin
              result_d = in_is_rem ? '0 : operandA;
              state_d  = ST_DONE;
`ifdef MULDIV_REMAINDER_CACHE_EN
            end else if (cache_hit) begin
              result_d = in_is_rem ? cache_rem_q : cache_quo_q;
              state_d  = ST_DONE;
`endif
            end else begin
              dvsr_d    = mag_b;
              rem_d     = step_rem;
              quo_d     = step_quo;
              quo_neg_d = in_signed && (operandA[XLEN-1] ^ operandB[XLEN-1]);
              rem_neg_d = in_signed && operandA[XLEN-1];
              cnt_d     = CNT_W'(XLEN - 1);
              state_d   = ST_DIV;
`ifdef MULDIV_REMAINDER_CACHE_EN
              pend_a_d      = operandA;
              pend_b_d      = operandB;
              pend_signed_d = in_signed;
`endif
            end
          end
        end
        ST_MUL: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d    = '0;
            result_d = mul_sel(op_q, prod_q);
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
        end
        ST_FIXUP: begin
          result_d = op_q[1] ? r_fix : q_fix;
          state_d  = ST_DONE;
`ifdef MULDIV_REMAINDER_CACHE_EN
          cache_valid_d  = 1'b1;
          cache_a_d      = pend_a_q;
          cache_b_d      = pend_b_q;
          cache_signed_d = pend_signed_q;
          cache_quo_d    = q_fix;
          cache_rem_d    = r_fix;
`endif
        end
        ST_DONE: begin
          if (resultReady) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
`ifdef MULDIV_REMAINDER_CACHE_EN
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      pend_a_q       <= '0;
      pend_b_q       <= '0;
      pend_signed_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
`ifdef MULDIV_REMAINDER_CACHE_EN
      cache_valid_q  <= cache_valid_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
      pend_a_q       <= pend_a_d;
      pend_b_q       <= pend_b_d;
      pend_signed_q  <= pend_signed_d;
`endif
    end
  end

  assign issueReady  = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resultValid = (state_q == ST_DONE);
  assign result      = result_q;
  assign resultTag   = tag_q;

endmodule
